mod_7_seq_monitor: RTL and testbench
====================================

Name: mod_7_seq_monitor

Overview:
- Downstream consumer of the mod-7 counter: samples its 3-bit count on every clock edge and checks the 0→1→…→6→0 sequence.
- Produces a registered wrap pulse on each 6→0 roll-over and keeps a saturating count of wraps.
- Flags sequence breaks and the illegal value 7.
- Sits beside the counter in Exp_5 benches and on-board builds as a self-checking observer and "period" event source for later stages.

Parameters:
- MOD, 7, modulus of the observed counter; legal values are 0..MOD-1.
- CNT_W, 3, width of the observed count.
- WRAP_W, 8, width of wrap_count and err_cnt.
- RESYNC_LEN, 7, consecutive correct steps needed to re-lock. Used only with MOD7_MON_RESYNC_EN.

Ports:
- clk  input  1  system clock, shared with the counter.
- rst  input  1  asynchronous, active-high reset, shared with the counter.
- count  input  CNT_W  counter output, sampled on every posedge clk.
- locked  output  1  monitor is tracking a valid sequence.
- wrap_pulse  output  1  one-cycle pulse per detected MOD-1→0 roll-over.
- wrap_count  output  WRAP_W  saturating number of roll-overs since reset.
- err  output  1  high while in ERROR state.
- err_illegal  output  1  sticky; count ≥ MOD was sampled since reset.
- err_cnt  output  WRAP_W  saturating number of LOCKED→ERROR transitions.

Behaviour:
- Reset (async, immediate, no clock needed):
  - state=SYNC, prev=0.
  - All outputs 0.
- Registers: prev (CNT_W), state (SYNC/LOCKED/ERROR), wrap_count, err_cnt, err_illegal, wrap_pulse, resync counter (only when the optional feature is compiled in).
- Expected value: exp = (prev==MOD-1) ? 0 : prev+1. No arithmetic wider than CNT_W.
- SYNC:
  - First edge after reset release: prev<=count.
  - If count<MOD, go to LOCKED; otherwise go to ERROR.
  - No error or wrap is reported from SYNC.
- LOCKED, every edge: prev<=count.
  - count==exp:
    - Stay in LOCKED.
    - If prev==MOD-1 and count==0, then wrap_pulse<=1 and wrap_count<=wrap_count+1, saturating at all-ones.
  - count!=exp:
    - Go to ERROR, with wrap_pulse<=0.
    - err_cnt increments (saturating).
- ERROR: prev<=count every edge. Exit is defined under Optional Feature.
- wrap_pulse:
  - Latency: 1 cycle after the edge that samples the 0 following a MOD-1.
  - Width: exactly 1 cycle; deasserted on every other edge.
- err_illegal:
  - Set on any edge where count≥MOD, in any state, including the first sample in SYNC.
  - Cleared only by rst.
  - An illegal value in LOCKED is also a mismatch, so it produces the ERROR transition too.
- Outputs:
  - locked = (state==LOCKED).
  - err = (state==ERROR).
  - Both are registered state decodes, so they change on the edge after the offending sample.
- Simultaneous events: a sample that both mismatches and is illegal produces one err_cnt increment and sets err_illegal in the same edge.
- Reset mid-operation: immediate return to SYNC. Counters are cleared.

Optional Feature:
- Macro: MOD7_MON_RESYNC_EN.
- Defined:
  - In ERROR, a resync counter counts consecutive edges where count==exp.
  - A mismatch zeroes the resync counter.
  - On reaching RESYNC_LEN, go to LOCKED and zero the resync counter.
  - No wrap pulses are issued while in ERROR.
- Undefined:
  - ERROR is absorbing until rst.
  - No resync counter is synthesised.

Decomposition:
- Package mod7_mon_pkg:
  - Constants MOD7_MOD=7, MOD7_CNT_W=3.
  - Typedef mon_state_t enum {SYNC, LOCKED, ERROR}.
  - Function next_exp(prev, mod).
- One natural combinational sub-module, mod_7_next_calc: computes exp and the wrap condition from prev and count. It is reused by the checker inside the testbench.

Test Plan:
- rst=1 for 20 ns (period 20 ns), release, drive 0,1,…,6,0 → locked=1 after first edge; wrap_pulse=1 for exactly one cycle, one edge after the 0 is sampled; wrap_count=1; err=0.
- Clean run of 20 samples starting at 0 → roll-overs are taken at sample indices 7 and 14; wrap_count=2; err_cnt=0; err_illegal=0.
- Sequence 0,1,2,4 → err=1 and locked=0 on the edge after the 4 is sampled; err_cnt=1; no wrap_pulse. Without MOD7_MON_RESYNC_EN, err stays 1 for 20 further clean cycles.
- Drive count=7 while LOCKED → err_illegal=1 and err=1; err_illegal still 1 after 10 cycles of valid counting, until rst.
- Assert rst mid-cycle while in ERROR with wrap_count=3 → all outputs 0 before the next clk edge; after release, locked=1 on the first edge.
- With MOD7_MON_RESYNC_EN, RESYNC_LEN=7:
  - Break at 2→4, then continue 5,6,0,1,2,3,4 → locked=1 after the 7th correct step.
  - err_cnt=1.
  - The later 6→0 crossing during ERROR gives no wrap_pulse.
- Optionally add a WRAP_W=2 variant → after 5 wraps, wrap_count=3 (saturated).

Source files
------------

// File: rtl/mod7_mon_pkg.sv
// mod7_mon_pkg: shared constants, state encoding and the expected-next-value
// helper for the mod-7 sequence monitor.
//   MOD7_MOD     modulus of the observed counter
//   MOD7_CNT_W   width of the observed count
//   mon_state_t  SYNC / LOCKED / ERROR
//   next_exp()   value that should follow 'prev' in a 0..mod-1 sequence
package mod7_mon_pkg;

  localparam int unsigned MOD7_MOD   = 32'd7;
  localparam int unsigned MOD7_CNT_W = 32'd3;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } mon_state_t;

  // Successor in the modulo sequence, kept to MOD7_CNT_W bits so an illegal
  // 'prev' simply wraps in the count width instead of growing.
  function automatic logic [MOD7_CNT_W-1:0] next_exp(
    input logic [MOD7_CNT_W-1:0] prev,
    input int unsigned           mod
  );
    logic [MOD7_CNT_W-1:0] last;
    last = MOD7_CNT_W'(mod - 32'd1);
    if (prev == last) begin
      next_exp = {MOD7_CNT_W{1'b0}};
    end else begin
      next_exp = prev + {{(MOD7_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/mod_7_next_calc.sv
// mod_7_next_calc: combinational step predictor for the mod-7 monitor.
// Ports:
//   prev     previously sampled count
//   count    currently sampled count
//   exp_cnt  value that should follow prev
//   wrap     prev is MOD-1 and count is 0 (a roll-over, if in sequence)
module mod_7_next_calc
  import mod7_mon_pkg::*;
#(
  parameter int unsigned MOD   = MOD7_MOD,
  parameter int unsigned CNT_W = MOD7_CNT_W
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] exp_cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 32'd1);

  assign exp_cnt = next_exp(prev, MOD);
  assign wrap    = (prev == LAST) && (count == {CNT_W{1'b0}});

endmodule

// File: rtl/mod_7_seq_monitor.sv
// mod_7_seq_monitor: observer for a mod-7 counter. Samples count on every
// clock edge, checks the 0..MOD-1 sequence, emits a registered wrap pulse on
// each MOD-1 -> 0 roll-over and keeps saturating wrap / error counts.
// Ports:
//   clk, rst     clock and asynchronous active-high reset (shared with counter)
//   count        observed counter value
//   locked       monitor is tracking a valid sequence
//   wrap_pulse   one-cycle pulse per roll-over
//   wrap_count   saturating number of roll-overs
//   err          monitor is in ERROR
//   err_illegal  sticky: a value >= MOD was sampled
//   err_cnt      saturating number of LOCKED -> ERROR transitions
// Optional macro MOD7_MON_RESYNC_EN: ERROR re-locks after RESYNC_LEN
// consecutive correct steps; without it ERROR holds until rst.
module mod_7_seq_monitor
  import mod7_mon_pkg::*;
#(
  parameter int unsigned MOD        = MOD7_MOD,
  parameter int unsigned CNT_W      = MOD7_CNT_W,
  parameter int unsigned WRAP_W     = 32'd8,
  parameter int unsigned RESYNC_LEN = 32'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  count,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic              err_illegal,
  output logic [WRAP_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(MOD - 32'd1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(32'd1);
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  mon_state_t        state_r, state_nxt_s;
  logic [CNT_W-1:0]  prev_r;
  logic [WRAP_W-1:0] wrap_count_r, err_cnt_r;
  logic              err_illegal_r, wrap_pulse_r;
  logic [CNT_W-1:0]  exp_s;
  logic              wrap_s, match_s, illegal_s;
  logic              wrap_evt_s, err_evt_s;

`ifdef MOD7_MON_RESYNC_EN
  localparam int unsigned      RS_W    = $clog2(RESYNC_LEN + 32'd1);
  localparam logic [RS_W-1:0]  RS_ONE  = RS_W'(32'd1);
  localparam logic [RS_W-1:0]  RS_LAST = RS_W'(RESYNC_LEN - 32'd1);
  logic [RS_W-1:0] resync_cnt_r, resync_nxt_s;
`endif

  mod_7_next_calc #(
    .MOD   (MOD),
    .CNT_W (CNT_W)
  ) u_next_calc (
    .prev    (prev_r),
    .count   (count),
    .exp_cnt (exp_s),
    .wrap    (wrap_s)
  );

  assign match_s   = (count == exp_s);
  assign illegal_s = (count > LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic plus the wrap / error events of this edge.
  always_comb begin
    state_nxt_s = state_r;
    wrap_evt_s  = 1'b0;
    err_evt_s   = 1'b0;
`ifdef MOD7_MON_RESYNC_EN
    resync_nxt_s = {RS_W{1'b0}};
`endif
    case (state_r)
      SYNC: begin
        // First sample only establishes prev; nothing is reported yet.
        if (illegal_s) begin
          state_nxt_s = ERROR;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      LOCKED: begin
        if (match_s) begin
          state_nxt_s = LOCKED;
          wrap_evt_s  = wrap_s;
        end else begin
          state_nxt_s = ERROR;
          err_evt_s   = 1'b1;
        end
      end
      ERROR: begin
`ifdef MOD7_MON_RESYNC_EN
        if (match_s) begin
          if (resync_cnt_r == RS_LAST) begin
            state_nxt_s  = LOCKED;
            resync_nxt_s = {RS_W{1'b0}};
          end else begin
            state_nxt_s  = ERROR;
            resync_nxt_s = resync_cnt_r + RS_ONE;
          end
        end else begin
          state_nxt_s  = ERROR;
          resync_nxt_s = {RS_W{1'b0}};
        end
`else
        state_nxt_s = ERROR;
`endif
      end
      default: begin
        state_nxt_s = SYNC;
      end
    endcase
  end

  // Sample history, pulse and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r        <= {CNT_W{1'b0}};
      wrap_pulse_r  <= 1'b0;
      wrap_count_r  <= {WRAP_W{1'b0}};
      err_cnt_r     <= {WRAP_W{1'b0}};
      err_illegal_r <= 1'b0;
    end else begin
      prev_r       <= count;
      wrap_pulse_r <= wrap_evt_s;
      if (illegal_s) begin
        err_illegal_r <= 1'b1;
      end else begin
        err_illegal_r <= err_illegal_r;
      end
      if (wrap_evt_s && (wrap_count_r != WRAP_MAX)) begin
        wrap_count_r <= wrap_count_r + WRAP_ONE;
      end else begin
        wrap_count_r <= wrap_count_r;
      end
      if (err_evt_s && (err_cnt_r != WRAP_MAX)) begin
        err_cnt_r <= err_cnt_r + WRAP_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

`ifdef MOD7_MON_RESYNC_EN
  // Consecutive-correct-step counter used only while in ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resync_cnt_r <= {RS_W{1'b0}};
    end else begin
      resync_cnt_r <= resync_nxt_s;
    end
  end
`endif

  // Output decode: flags come straight from the state register.
  always_comb begin
    locked = 1'b0;
    err    = 1'b0;
    case (state_r)
      LOCKED:  locked = 1'b1;
      ERROR:   err    = 1'b1;
      default: begin
        locked = 1'b0;
        err    = 1'b0;
      end
    endcase
  end

  assign wrap_pulse  = wrap_pulse_r;
  assign wrap_count  = wrap_count_r;
  assign err_cnt     = err_cnt_r;
  assign err_illegal = err_illegal_r;

endmodule

// File: tb/tb_mod_7_seq_monitor.sv
// Testbench for mod_7_seq_monitor: a hand-written vector table for the first
// roll-over, then scoreboarded sequences against a behavioural model, plus
// direct checks on reset, error latching, illegal values and saturation.
module tb_mod_7_seq_monitor;

  logic       clk;
  logic       rst;
  logic [2:0] count;
  logic       locked, wrap_pulse, err, err_illegal;
  logic [7:0] wrap_count, err_cnt;

  mod_7_seq_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .count       (count),
    .locked      (locked),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .err         (err),
    .err_illegal (err_illegal),
    .err_cnt     (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct packed {
    logic       locked;
    logic       err;
    logic       wrap;
    logic       ill;
    logic [7:0] wc;
    logic [7:0] ec;
  } obs_t;

  typedef struct {
    logic [2:0] count;
    logic       locked;
    logic       wrap;
    logic       err;
    logic [7:0] wc;
  } vec_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Behavioural model state: 0 = SYNC, 1 = LOCKED, 2 = ERROR.
  int         m_state;
  logic [2:0] m_prev;
  logic [7:0] m_wc, m_ec;
  logic       m_ill;
  int         m_rs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_prev  = 3'd0;
    m_wc    = 8'd0;
    m_ec    = 8'd0;
    m_ill   = 1'b0;
    m_rs    = 0;
  endtask

  task automatic model_step(input logic [2:0] c);
    logic [2:0] e;
    int         ns;
    logic       wp;
    obs_t       o;
    e  = (m_prev == 3'd6) ? 3'd0 : 3'(m_prev + 3'd1);
    ns = m_state;
    wp = 1'b0;
    case (m_state)
      0: ns = (c == 3'd7) ? 2 : 1;
      1: begin
        if (c == e) begin
          if (m_prev == 3'd6) begin
            wp = 1'b1;
            if (m_wc != 8'hFF) m_wc = m_wc + 8'd1;
          end
        end else begin
          ns = 2;
          if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        end
      end
      default: begin
`ifdef MOD7_MON_RESYNC_EN
        if (c == e) begin
          m_rs++;
          if (m_rs == 7) begin
            ns   = 1;
            m_rs = 0;
          end
        end else begin
          m_rs = 0;
        end
`endif
      end
    endcase
    if (c == 3'd7) m_ill = 1'b1;
    m_prev  = c;
    m_state = ns;
    o.locked = (ns == 1);
    o.err    = (ns == 2);
    o.wrap   = wp;
    o.ill    = m_ill;
    o.wc     = m_wc;
    o.ec     = m_ec;
    sb_q.push_back(o);
  endtask

  // Drive one sample, let the DUT take it, then compare against the model.
  task automatic step(input logic [2:0] c);
    obs_t a, e;
    count = c;
    model_step(c);
    @(posedge clk);
    #1;
    cyc++;
    a = {locked, err, wrap_pulse, err_illegal, wrap_count, err_cnt};
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("cyc%0d_count%0d", cyc, c), 32'(a), 32'(e));
    end
  endtask

  // Assert rst away from the clock edge and confirm immediate clearing.
  task automatic apply_reset(input string name);
    #4;
    rst = 1'b1;
    #1;
    check(name, 32'({locked, err, wrap_pulse, err_illegal, wrap_count, err_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  vec_t vec[9];

  initial begin
    vec[0] = '{3'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[1] = '{3'd1, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[2] = '{3'd2, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[3] = '{3'd3, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[4] = '{3'd4, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[5] = '{3'd5, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[6] = '{3'd6, 1'b1, 1'b0, 1'b0, 8'd0};
    vec[7] = '{3'd0, 1'b1, 1'b1, 1'b0, 8'd1};
    vec[8] = '{3'd1, 1'b1, 1'b0, 1'b0, 8'd1};

    rst   = 1'b1;
    count = 3'd0;
    model_reset();
    @(posedge clk);
    #1;
    check("reset_state", 32'({locked, err, wrap_pulse, err_illegal, wrap_count, err_cnt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First roll-over from a hand-written table.
    for (int i = 0; i < 9; i++) begin
      step(vec[i].count);
      check($sformatf("vec%0d", i),
            32'({locked, wrap_pulse, err, wrap_count}),
            32'({vec[i].locked, vec[i].wrap, vec[i].err, vec[i].wc}));
    end

    // Clean run of 20 samples: roll-overs at indices 7 and 14.
    apply_reset("reset_before_clean");
    for (int i = 0; i < 20; i++) begin
      step(3'(i % 7));
      if (i == 7 || i == 14) check($sformatf("clean_wrap_at_%0d", i), 32'(wrap_pulse), 32'd1);
    end
    check("clean_wrap_count", 32'(wrap_count), 32'd2);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);
    check("clean_err_illegal", 32'(err_illegal), 32'd0);

    // Sequence break 2 -> 4.
    apply_reset("reset_before_break");
    step(3'd0); step(3'd1); step(3'd2); step(3'd4);
    check("break_err", 32'({err, locked, wrap_pulse}), 32'b100);
    check("break_err_cnt", 32'(err_cnt), 32'd1);
    for (int i = 5; i < 12; i++) step(3'(i % 7));
`ifdef MOD7_MON_RESYNC_EN
    check("resync_locked", 32'({locked, err}), 32'b10);
    check("resync_no_wrap", 32'(wrap_count), 32'd0);
`else
    check("break_err_held", 32'({locked, err}), 32'b01);
`endif
    for (int i = 12; i < 25; i++) step(3'(i % 7));
    check("break_err_cnt_final", 32'(err_cnt), 32'd1);

    // Illegal value while LOCKED is sticky.
    apply_reset("reset_before_illegal");
    step(3'd0); step(3'd1); step(3'd2); step(3'd7);
    check("illegal_flags", 32'({err_illegal, err}), 32'b11);
    for (int i = 0; i < 10; i++) step(3'(i % 7));
    check("illegal_sticky", 32'(err_illegal), 32'd1);

    // Illegal first sample: ERROR straight from SYNC, no error counted.
    apply_reset("reset_before_sync_illegal");
    step(3'd7);
    check("sync_illegal", 32'({err, locked, err_illegal, err_cnt}), 32'({1'b1, 1'b0, 1'b1, 8'd0}));

    // Mid-cycle reset while in ERROR with three wraps recorded.
    apply_reset("reset_before_midrst");
    for (int i = 0; i < 22; i++) step(3'(i % 7));
    step(3'd1); step(3'd3);
    check("midrst_pre", 32'({err, wrap_count}), 32'({1'b1, 8'd3}));
    apply_reset("midrst_clear");
    step(3'd4);
    check("midrst_relock", 32'(locked), 32'd1);

    // Saturation after 256 roll-overs.
    apply_reset("reset_before_sat");
    for (int i = 0; i <= 256 * 7; i++) step(3'(i % 7));
    check("wrap_saturated", 32'(wrap_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
